// File: rtl/score_uart_tx.sv
// score_uart_tx: snapshots score/gameover on change, converts the score to three ASCII
// decimal digits and sends "S:ddd?\r\n" over txdata/txclk. Optional heartbeat: TX_HEARTBEAT_EN.
module score_uart_tx #(
    parameter int HEARTBEAT_TICKS = 5
) (
    input  logic       hz100,
    input  logic       reset,
    input  logic [7:0] score,
    input  logic       gameover,
    input  logic       onehuzz,
    input  logic       txready,
    output logic [7:0] txdata,
    output logic       txclk,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CONVERT, SEND, GAP} state_t;
    state_t state, state_next;

    logic [7:0] last_score;
    logic       last_go;
    logic [7:0] rem;
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] ones;
    logic [2:0] idx;
    logic       hb_pend;
    logic       event_hit;
    logic       rem_ge100;
    logic       rem_ge10;
    logic       load_snap;
    logic       step_h;
    logic       step_t;
    logic       finish_conv;
    logic       emit;
    logic       advance;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'd0, d};
    endfunction

    function automatic logic [7:0] msg_byte(input logic [2:0] i, input logic [1:0] hd,
                                            input logic [3:0] td, input logic [3:0] od,
                                            input logic go);
        logic [7:0] b;
        case (i)
            3'd0:    b = 8'h53;
            3'd1:    b = 8'h3A;
            3'd2:    b = ascii_digit({2'b00, hd});
            3'd3:    b = ascii_digit(td);
            3'd4:    b = ascii_digit(od);
            3'd5:    b = go ? 8'h21 : 8'h20;
            3'd6:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    assign rem_ge100 = (rem >= 8'd100);
    assign rem_ge10  = (rem >= 8'd10);
    assign event_hit = (score != last_score) || (gameover != last_go) || hb_pend;

`ifdef TX_HEARTBEAT_EN
    localparam int CNT_W = (HEARTBEAT_TICKS > 1) ? $clog2(HEARTBEAT_TICKS) : 1;
    logic [CNT_W-1:0] hb_cnt;

    // Ticks keep counting mid-message; the pending flag waits for the next IDLE.
    always_ff @(posedge hz100) begin
        if (reset) begin
            hb_cnt  <= '0;
            hb_pend <= 1'b0;
        end else begin
            if (load_snap)
                hb_pend <= 1'b0;
            if (onehuzz) begin
                if (hb_cnt == CNT_W'(HEARTBEAT_TICKS - 1)) begin
                    hb_cnt  <= '0;
                    hb_pend <= 1'b1;
                end else begin
                    hb_cnt <= hb_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_onehuzz;
    assign unused_onehuzz = onehuzz;
    assign hb_pend        = 1'b0;
`endif

    always_ff @(posedge hz100) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (event_hit) state_next = CONVERT;
            CONVERT: if (!rem_ge100 && !rem_ge10) state_next = SEND;
            SEND:    if (txready) state_next = GAP;
            GAP:     state_next = (idx == 3'd7) ? IDLE : SEND;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        load_snap   = 1'b0;
        step_h      = 1'b0;
        step_t      = 1'b0;
        finish_conv = 1'b0;
        emit        = 1'b0;
        advance     = 1'b0;
        unique case (state)
            IDLE:    load_snap = event_hit;
            CONVERT: begin
                busy        = 1'b1;
                step_h      = rem_ge100;
                step_t      = !rem_ge100 && rem_ge10;
                finish_conv = !rem_ge100 && !rem_ge10;
            end
            SEND: begin
                busy = 1'b1;
                emit = txready;
            end
            GAP: begin
                busy    = 1'b1;
                advance = (idx != 3'd7);
            end
            default: busy = 1'b0;
        endcase
    end

    // Snapshot and transmit registers; txdata holds until the next strobe.
    always_ff @(posedge hz100) begin
        if (reset) begin
            last_score <= 8'd0;
            last_go    <= 1'b0;
            txdata     <= 8'h00;
            txclk      <= 1'b0;
        end else begin
            txclk <= emit;
            if (load_snap) begin
                last_score <= score;
                last_go    <= gameover;
            end
            if (emit)
                txdata <= msg_byte(idx, h, t, ones, last_go);
        end
    end

    // Subtract-based binary to decimal: one hundreds or tens step per cycle.
    always_ff @(posedge hz100) begin
        if (load_snap) begin
            rem <= score;
            h   <= 2'd0;
            t   <= 4'd0;
        end else if (step_h) begin
            rem <= rem - 8'd100;
            h   <= h + 2'd1;
        end else if (step_t) begin
            rem <= rem - 8'd10;
            t   <= t + 4'd1;
        end
        if (finish_conv) begin
            ones <= rem[3:0];
            idx  <= 3'd0;
        end else if (advance) begin
            idx <= idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_score_uart_tx.sv
// Directed bench for score_uart_tx: reset, conversion, stall, coalescing, abort, heartbeat.
module tb_score_uart_tx;
    logic       hz100 = 1'b0;
    logic       reset;
    logic [7:0] score;
    logic       gameover;
    logic       onehuzz;
    logic       txready;
    logic [7:0] txdata;
    logic       txclk;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] cap [0:19];
    int         capk [0:19];
    int         ncap;
    logic       busy_last;
    logic       busy_after;

    score_uart_tx #(.HEARTBEAT_TICKS(5)) dut (
        .hz100   (hz100),
        .reset   (reset),
        .score   (score),
        .gameover(gameover),
        .onehuzz (onehuzz),
        .txready (txready),
        .txdata  (txdata),
        .txclk   (txclk),
        .busy    (busy)
    );

    always #5 hz100 = ~hz100;

    // Records up to 8 strobes; k counts negedges after the stimulus negedge.
    task automatic collect(input int budget);
        int k;
        k = 0;
        ncap = 0;
        busy_last = 1'b0;
        while (ncap < 8 && k < budget) begin
            @(negedge hz100);
            k++;
            if (txclk) begin
                cap[ncap]  = txdata;
                capk[ncap] = k;
                busy_last  = busy;
                ncap++;
            end
        end
        @(negedge hz100);
        busy_after = busy;
    endtask

    task automatic test_reset;
        int strobes;
        int busies;
        reset = 1'b1; score = 8'd0; gameover = 1'b0; onehuzz = 1'b0; txready = 1'b1;
        repeat (3) @(negedge hz100);
        vectors++;
        if (txdata !== 8'h00 || txclk !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: txdata=%h txclk=%b busy=%b, want 00 0 0", txdata, txclk, busy);
        end
        reset = 1'b0;
        strobes = 0;
        busies = 0;
        repeat (50) begin
            @(negedge hz100);
            if (txclk) strobes++;
            if (busy) busies++;
        end
        vectors++;
        if (strobes != 0 || busies != 0) begin
            miscompares++;
            $display("FAIL idle_after_reset: strobes=%0d busy_cycles=%0d, want 0 0", strobes, busies);
        end
    endtask

    task automatic test_message(input logic [7:0] s, input logic g, input int first_k,
                                input logic [7:0] e2, input logic [7:0] e3,
                                input logic [7:0] e4, input logic [7:0] e5);
        logic [7:0] exp_b [0:7];
        exp_b[0] = 8'h53; exp_b[1] = 8'h3A; exp_b[2] = e2; exp_b[3] = e3;
        exp_b[4] = e4; exp_b[5] = e5; exp_b[6] = 8'h0D; exp_b[7] = 8'h0A;
        @(negedge hz100);
        score = s; gameover = g;
        collect(100);
        vectors++;
        if (ncap != 8) begin
            miscompares++;
            $display("FAIL msg_%0d_count: got %0d strobes, want 8", s, ncap);
        end else begin
            vectors++;
            if (capk[0] != first_k) begin
                miscompares++;
                $display("FAIL msg_%0d_latency: first strobe at %0d, want %0d", s, capk[0], first_k);
            end
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (cap[i] !== exp_b[i]) begin
                    miscompares++;
                    $display("FAIL msg_%0d_byte%0d: got %h, want %h", s, i, cap[i], exp_b[i]);
                end
                if (i > 0) begin
                    vectors++;
                    if (capk[i] - capk[i-1] != 2) begin
                        miscompares++;
                        $display("FAIL msg_%0d_spacing%0d: got %0d, want 2", s, i, capk[i] - capk[i-1]);
                    end
                end
            end
            vectors++;
            if (busy_last !== 1'b1 || busy_after !== 1'b0) begin
                miscompares++;
                $display("FAIL msg_%0d_busy_end: at_last=%b after=%b, want 1 0", s, busy_last, busy_after);
            end
        end
    endtask

    task automatic test_stall;
        int k;
        int n;
        int bad;
        logic [7:0] tail [0:3];
        tail[0] = 8'h35; tail[1] = 8'h21; tail[2] = 8'h0D; tail[3] = 8'h0A;
        @(negedge hz100);
        score = 8'd45;
        k = 0; n = 0;
        while (n < 3 && k < 100) begin
            @(negedge hz100);
            k++;
            if (txclk) n++;
        end
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL stall_prefix: got %0d strobes, want 3", n);
        end
        txready = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge hz100);
            if (txclk !== 1'b0 || txdata !== 8'h30) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stall_hold: %0d bad cycles (txclk=%b txdata=%h), want 0 (txdata 30)", bad, txclk, txdata);
        end
        txready = 1'b1;
        @(negedge hz100);
        vectors++;
        if (txclk !== 1'b1 || txdata !== 8'h34) begin
            miscompares++;
            $display("FAIL stall_release: txclk=%b txdata=%h, want 1 34", txclk, txdata);
        end
        n = 0; k = 0;
        while (n < 4 && k < 40) begin
            @(negedge hz100);
            k++;
            if (txclk) begin
                vectors++;
                if (txdata !== tail[n]) begin
                    miscompares++;
                    $display("FAIL stall_tail%0d: got %h, want %h", n, txdata, tail[n]);
                end
                n++;
            end
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL stall_tail_count: got %0d, want 4", n);
        end
        repeat (3) @(negedge hz100);
    endtask

    task automatic test_back_to_back;
        int n;
        logic [7:0] exp_b [0:15];
        exp_b[0] = 8'h53; exp_b[1] = 8'h3A; exp_b[2] = 8'h30; exp_b[3] = 8'h30;
        exp_b[4] = 8'h37; exp_b[5] = 8'h20; exp_b[6] = 8'h0D; exp_b[7] = 8'h0A;
        exp_b[8] = 8'h53; exp_b[9] = 8'h3A; exp_b[10] = 8'h30; exp_b[11] = 8'h30;
        exp_b[12] = 8'h39; exp_b[13] = 8'h20; exp_b[14] = 8'h0D; exp_b[15] = 8'h0A;
        @(negedge hz100);
        score = 8'd7; gameover = 1'b0;
        n = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge hz100);
            if (txclk) begin
                if (n < 16) begin
                    vectors++;
                    if (txdata !== exp_b[n]) begin
                        miscompares++;
                        $display("FAIL coalesce_byte%0d: got %h, want %h", n, txdata, exp_b[n]);
                    end
                end
                n++;
            end
            if (k == 8) score = 8'd8;
            if (k == 12) score = 8'd9;
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL coalesce_count: got %0d strobes, want 16", n);
        end
    endtask

    task automatic test_abort;
        int k;
        int n;
        @(negedge hz100);
        score = 8'd200;
        k = 0; n = 0;
        while (n < 4 && k < 100) begin
            @(negedge hz100);
            k++;
            if (txclk) n++;
        end
        @(negedge hz100);
        reset = 1'b1; score = 8'd0; gameover = 1'b0;
        @(negedge hz100);
        vectors++;
        if (txclk !== 1'b0 || txdata !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: txclk=%b txdata=%h busy=%b, want 0 00 0", txclk, txdata, busy);
        end
        reset = 1'b0;
        n = 0;
        repeat (30) begin
            @(negedge hz100);
            if (txclk || busy) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL abort_no_resume: %0d active cycles, want 0", n);
        end
    endtask

    task automatic test_heartbeat;
        int n;
        n = 0;
        for (int p = 0; p < 5; p++) begin
            @(negedge hz100); onehuzz = 1'b1;
            @(negedge hz100); onehuzz = 1'b0;
            if (txclk) n++;
            repeat (3) begin
                @(negedge hz100);
                if (txclk) n++;
            end
        end
`ifdef TX_HEARTBEAT_EN
        collect(60);
        vectors++;
        if (ncap != 8 || cap[2] !== 8'h30 || cap[4] !== 8'h30 || cap[5] !== 8'h20) begin
            miscompares++;
            $display("FAIL heartbeat_resend: strobes=%0d b2=%h b4=%h b5=%h, want 8 30 30 20",
                     ncap, cap[2], cap[4], cap[5]);
        end
`else
        repeat (40) begin
            @(negedge hz100);
            if (txclk) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL heartbeat_disabled: %0d strobes, want 0", n);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_message(8'd123, 1'b0, 6, 8'h31, 8'h32, 8'h33, 8'h20);
        test_message(8'd255, 1'b1, 10, 8'h32, 8'h35, 8'h35, 8'h21);
        test_stall();
        test_back_to_back();
        test_abort();
        test_heartbeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
